// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: widths, round counts, FSM encoding,
// round-constant generation and the single-round permutation datapath.
package ascon_pkg;

    localparam int ASCON_STATE_W    = 320;
    localparam int ASCON_LANE_W     = 64;
    localparam int ASCON_PA_ROUNDS  = 12;
    localparam int ASCON_PB6_ROUNDS = 6;
    localparam int ASCON_PB8_ROUNDS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perm_state_t;

    // Constant for table position ci (0..11): upper nibble counts down from F.
    function automatic logic [7:0] rc(input logic [3:0] ci);
        return {4'hF - ci, ci};
    endfunction

    // One full round: constant addition, bitsliced 5-bit S-box, lane diffusion.
    function automatic logic [ASCON_STATE_W-1:0] ascon_round(
        input logic [ASCON_STATE_W-1:0] s,
        input logic [3:0]               ci
    );
        logic [ASCON_LANE_W-1:0] x0, x1, x2, x3, x4;
        logic [ASCON_LANE_W-1:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];

        x2 = x2 ^ {56'd0, rc(ci)};

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
        x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
        x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
        x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
        x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};

        return {x0, x1, x2, x3, x4};
    endfunction

endpackage

// File: rtl/ascon_round_ctrl.sv
// Sequencing control for the iterative permutation: handshake FSM,
// round counter, clamped round count and constant-index generation.
module ascon_round_ctrl
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS = 12,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] nrounds,
    input  logic             abort,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             accept,
    output logic             step,
    output logic [CNT_W-1:0] rc_idx,
    output logic [1:0]       fsm_state
);

    perm_state_t      state, state_nxt;
    logic [CNT_W-1:0] k, n_reg, n_clamp, ci_run;
    logic             last;

    assign n_clamp = (nrounds > CNT_W'(MAX_ROUNDS)) ? CNT_W'(MAX_ROUNDS) : nrounds;
    assign ci_run  = CNT_W'(MAX_ROUNDS) - n_reg + k;
    assign last    = (k == n_reg - CNT_W'(1));
    assign accept  = in_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort takes priority over both round completion and the output handshake.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = (n_clamp == '0) ? DONE : RUN;
            RUN:  if (abort) state_nxt = IDLE;
                  else if (last) state_nxt = DONE;
            DONE: if (abort || out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        step      = (state == RUN) && !abort;
        rc_idx    = (state == RUN) ? ci_run : '0;
        fsm_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k     <= '0;
            n_reg <= '0;
        end else if (accept) begin
            k     <= '0;
            n_reg <= n_clamp;
        end else if (step) begin
            k <= k + CNT_W'(1);
        end else if (abort && state != IDLE) begin
            k <= '0;
        end
    end

endmodule

// File: rtl/ascon_perm_sequencer.sv
// Iterative Ascon permutation: owns the 320-bit state and applies one
// round per clock under control of ascon_round_ctrl.
module ascon_perm_sequencer
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS = 12,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [319:0]     state_in,
    input  logic [CNT_W-1:0] nrounds,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [319:0]     state_out,
    output logic             busy,
    output logic [CNT_W-1:0] rc_idx
);

    logic         accept, step;
    logic [1:0]   fsm_state;
    logic [319:0] state_reg;

    ascon_round_ctrl #(
        .MAX_ROUNDS(MAX_ROUNDS),
        .CNT_W     (CNT_W)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .nrounds  (nrounds),
        .abort    (abort),
        .out_ready(out_ready),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .accept   (accept),
        .step     (step),
        .rc_idx   (rc_idx),
        .fsm_state(fsm_state)
    );

    // State is only written on accept or on a live round; DONE and abort freeze it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
        end else if (accept) begin
            state_reg <= state_in;
        end else if (step) begin
            state_reg <= ascon_round(state_reg, 4'(rc_idx));
        end
    end

    assign state_out = state_reg;
    assign busy      = (fsm_state != 2'(IDLE));

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Randomized self-checking bench for ascon_perm_sequencer against a
// table-driven Ascon reference model.
module tb_ascon_perm_sequencer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [319:0] state_in;
    logic [3:0]   nrounds;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [319:0] state_out;
    logic         busy;
    logic [3:0]   rc_idx;

    int n_checks = 0;
    int n_errors = 0;
    logic [319:0] exp_q[$];

    logic [7:0] rc_tab  [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
    logic [4:0] sbox_tab[32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    int rot_a[5] = '{19, 61, 1, 10, 7};
    int rot_b[5] = '{28, 39, 6, 17, 41};

    ascon_perm_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .state_in (state_in),
        .nrounds  (nrounds),
        .abort    (abort),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .state_out(state_out),
        .busy     (busy),
        .rc_idx   (rc_idx)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // reference model: column-wise S-box lookup and lane rotations
    function automatic logic [63:0] ror(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    function automatic logic [319:0] model_round(input logic [319:0] s, input int ci);
        logic [63:0] x[5];
        logic [63:0] y[5];
        logic [4:0]  col, o;
        for (int l = 0; l < 5; l++) x[l] = s[319 - 64*l -: 64];
        x[2] = x[2] ^ 64'(rc_tab[ci]);
        for (int i = 0; i < 64; i++) begin
            col = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
            o   = sbox_tab[col];
            for (int l = 0; l < 5; l++) y[l][i] = o[4 - l];
        end
        for (int l = 0; l < 5; l++) y[l] = y[l] ^ ror(y[l], rot_a[l]) ^ ror(y[l], rot_b[l]);
        return {y[0], y[1], y[2], y[3], y[4]};
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
        logic [319:0] r;
        r = s;
        for (int j = 0; j < n; j++) r = model_round(r, 12 - n + j);
        return r;
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // driver: one full job, checking every RUN cycle, latency and the result
    task automatic run_job(input logic [319:0] s, input int nr, input int hold, input bit abort_at_accept);
        int           neff, cyc;
        logic [319:0] cur, held;
        neff = (nr > 12) ? 12 : nr;
        check("accept_ready", 320'(in_ready), 320'(1));
        in_valid = 1'b1;
        state_in = s;
        nrounds  = 4'(nr);
        abort    = abort_at_accept;
        exp_q.push_back(model_perm(s, neff));
        cur = s;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        cyc      = 1;
        while (!out_valid && cyc <= 40) begin
            check("run_busy", 320'(busy), 320'(1));
            check("run_in_ready", 320'(in_ready), 320'(0));
            check("run_rc_idx", 320'(rc_idx), 320'(12 - neff + cyc - 1));
            check("run_state", state_out, cur);
            if (cyc <= neff) cur = model_round(cur, 12 - neff + cyc - 1);
            @(negedge clk);
            cyc++;
        end
        check("latency", 320'(cyc), 320'(neff + 1));
        check("done_valid", 320'(out_valid), 320'(1));
        check("done_state", state_out, exp_q.pop_front());
        held = state_out;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            state_in = rand_state();
            nrounds  = 4'($urandom_range(0, 15));
            @(negedge clk);
            check("hold_valid", 320'(out_valid), 320'(1));
            check("hold_in_ready", 320'(in_ready), 320'(0));
            check("hold_state", state_out, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_in_ready", 320'(in_ready), 320'(1));
        check("post_out_valid", 320'(out_valid), 320'(0));
    endtask

    task automatic abort_job(input int at_cycle);
        in_valid = 1'b1;
        state_in = rand_state();
        nrounds  = 4'd12;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c < at_cycle; c++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_ready", 320'(in_ready), 320'(1));
        check("abort_busy", 320'(busy), 320'(0));
        for (int c = 0; c < 6; c++) begin
            check("abort_no_valid", 320'(out_valid), 320'(0));
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        state_in  = '0;
        nrounds   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 320'(in_ready), 320'(1));
        check("rst_out_valid", 320'(out_valid), 320'(0));
        check("rst_busy", 320'(busy), 320'(0));
        check("rst_state", state_out, 320'(0));
        check("rst_rc_idx", 320'(rc_idx), 320'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_job('0, 12, 0, 1'b0);
        run_job('0, 6, 1, 1'b0);
        run_job('0, 8, 0, 1'b0);
        run_job(rand_state(), 0, 2, 1'b0);
        run_job(rand_state(), 15, 0, 1'b0);
        run_job(rand_state(), 8, 20, 1'b0);
        abort_job(3);
        run_job(rand_state(), 6, 0, 1'b0);
        run_job(rand_state(), 6, 1, 1'b1);
        for (int j = 0; j < 12; j++)
            run_job(rand_state(), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0);

        // asynchronous reset in the middle of a p^12 run
        in_valid = 1'b1;
        state_in = rand_state();
        nrounds  = 4'd12;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", 320'(busy), 320'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 320'(in_ready), 320'(1));
        check("mid_rst_out_valid", 320'(out_valid), 320'(0));
        check("mid_rst_state", state_out, 320'(0));
        check("mid_rst_rc_idx", 320'(rc_idx), 320'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("scoreboard_empty", 320'(exp_q.size()), 320'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ascon_perm_sequencer.md
Name: ascon_perm_sequencer

Overview:
Iterative controller for the 320-bit Ascon permutation. It owns the 320-bit state register and applies one round per clock through a single combinational round datapath (constant addition, substitution layer, linear diffusion). It runs p^a (12 rounds) or p^b (6/8 rounds) on request, behind a valid/ready handshake. The mode/AEAD FSM uses it to schedule initialization, associated-data, plaintext and finalization permutations.

Parameters:
MAX_ROUNDS, 12, total round-constant table length; the constant index base is MAX_ROUNDS - nrounds.
CNT_W, 4, width of the round counter and of the nrounds input.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  sequencer idle and able to accept
state_in  input  320  initial state S = x0||x1||x2||x3||x4, x0 in [319:256]
nrounds  input  CNT_W  rounds to apply, legal 0..12
abort  input  1  synchronous cancel of the current job
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
state_out  output  320  permuted state, direct view of the state register
busy  output  1  high in RUN or DONE
rc_idx  output  CNT_W  constant index of the round currently applied, for debug/trace

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, state_reg=0, k=0, n_reg=0. Outputs: in_ready=1, out_valid=0, busy=0, state_out=0, rc_idx=0.
- FSM states:
  - IDLE -> RUN on accept (in_valid && in_ready) with nrounds>=1.
  - IDLE -> DONE on accept with nrounds==0 (pass-through).
  - RUN -> DONE after the last round.
  - DONE -> IDLE on out_valid && out_ready.
- in_ready = (FSM==IDLE). out_valid = (FSM==DONE).
- Accept: state_reg <= state_in, k <= 0, n_reg <= min(nrounds, 12). Values above 12 are clamped to 12.
- RUN, each cycle:
  - ci = 12 - n_reg + k, driven on rc_idx.
  - Round constant = {(4'hF - ci), ci}, XORed into x2 by the datapath.
  - state_reg <= round(state_reg, ci); k <= k+1.
  - When k == n_reg-1: transition to DONE on that same edge.
- Latency: out_valid rises exactly n+1 cycles after the accepting edge (n>=1). For n=0 it rises 1 cycle after.
- DONE: state_reg frozen. state_out is stable until the handshake completes. No new request is accepted while out_valid is held.
- Back-to-back: in_ready returns the cycle after the out handshake. There is no same-cycle accept/complete overlap (throughput is one job per n+2 cycles).
- abort=1 in RUN or DONE: next edge goes to IDLE with k=0. state_reg is retained but out_valid is never raised for that job. abort in IDLE is ignored. If abort and in_valid are both high in IDLE, the accept proceeds.
- in_valid while busy is ignored; the requester must hold it until in_ready.
- state_out in RUN shows intermediate states; consumers qualify it with out_valid.
- The counter never wraps: k is bounded by n_reg-1 <= 11.

Decomposition:
- Shared package ascon_pkg holds:
  - constants ASCON_STATE_W=320, ASCON_LANE_W=64, ASCON_PA_ROUNDS=12, ASCON_PB6_ROUNDS=6, ASCON_PB8_ROUNDS=8
  - the 12-entry round-constant function rc(ci)
  - FSM enum perm_state_t {IDLE, RUN, DONE}
- One natural sub-module: ascon_round_ctrl. It holds the FSM, k/n_reg counters and ci generation. The top level holds state_reg and instantiates the existing round datapath.

Test Plan:
1. Reset mid-RUN: start nrounds=12, pull rst_n low at round 5 -> in_ready=1, out_valid=0, state_out=0 immediately, with no clock edge needed.
2. p^12: state_in=0, nrounds=12 -> out_valid exactly 13 cycles after accept. rc_idx sequence is 0..11 (constants 0xF0,0xE1,...,0x4B). state_out matches the golden software model.
3. p^6 and p^8: the same state_in, nrounds=6 -> rc_idx 6..11 (constants 0x96..0x4B), latency 7. nrounds=8 -> rc_idx 4..11 (constants 0xB4..0x4B), latency 9. Both results match the golden model.
4. Backpressure: out_ready=0 for 20 cycles after done -> out_valid and state_out held constant, in_ready=0, a second in_valid is ignored. Raising out_ready gives in_ready=1 on the next cycle.
5. Edge counts: nrounds=0 -> state_out==state_in, out_valid 1 cycle after accept. nrounds=15 -> behaves as 12 (13-cycle latency, rc_idx 0..11).
6. Abort: abort at round 3 of p^12 -> IDLE next cycle, out_valid never asserted. A new p^6 request is then accepted and completes correctly.
